// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: issue/address generator feeding the NTT butterfly unit.
//
// For an N = 2^LOG_N point transform it walks LOG_N stages of N/2 butterflies.
// Each issue cycle carries the coefficient pair (a, b = a + len), the twiddle
// ROM index and the butterfly mode. Forward runs Cooley-Tukey order (len halves
// per stage); inverse runs Gentleman-Sande order (len doubles per stage). A
// PIPE_LAT-deep delay line replays each accepted pair as a write-back strobe.
//
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   start_i, inv_i            start request (IDLE only), 1 = inverse transform
//   busy_o, done_o            transform running / one-cycle completion pulse
//   issue_valid_o/ready_i     issue handshake
//   rd_a_idx_o, rd_b_idx_o    coefficient read indices
//   tw_idx_o, tw_neg_o        twiddle ROM index, negate twiddle
//   ct_mode_o                 1 = CT butterfly, 0 = GS butterfly
//   stage_o                   current stage, 0-based
//   wr_en_o, wr_a/b_idx_o     delayed write-back strobe and indices
module ntt_addr_gen #(
  parameter int unsigned LOG_N    = 8,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        start_i,
  input  logic                                        inv_i,
  output logic                                        busy_o,
  output logic                                        done_o,
  output logic                                        issue_valid_o,
  input  logic                                        issue_ready_i,
  output logic [LOG_N-1:0]                            rd_a_idx_o,
  output logic [LOG_N-1:0]                            rd_b_idx_o,
  output logic [LOG_N-1:0]                            tw_idx_o,
  output logic                                        tw_neg_o,
  output logic                                        ct_mode_o,
  output logic [((LOG_N > 1) ? $clog2(LOG_N) : 1)-1:0] stage_o,
  output logic                                        wr_en_o,
  output logic [LOG_N-1:0]                            wr_a_idx_o,
  output logic [LOG_N-1:0]                            wr_b_idx_o
);

  localparam int unsigned StW  = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam int unsigned Half = 1 << (LOG_N - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [StW-1:0]   s_q, s_d;
  logic [LOG_N-1:0] c_q, c_d;
  logic             inv_q, inv_d;
  logic             ct_q, ct_d;

  logic [PIPE_LAT-1:0] pv_q, pv_d;
  logic [LOG_N-1:0]    pa_q [PIPE_LAT];
  logic [LOG_N-1:0]    pa_d [PIPE_LAT];
  logic [LOG_N-1:0]    pb_q [PIPE_LAT];
  logic [LOG_N-1:0]    pb_d [PIPE_LAT];

  logic             issuing;
  logic             fire;
  logic             pipe_empty;
  logic [StW-1:0]   lg;
  logic [LOG_N-1:0] len;
  logic [LOG_N-1:0] grp;
  logic [LOG_N-1:0] off;
  logic [LOG_N-1:0] idx_a;
  logic [LOG_N-1:0] idx_b;
  logic [LOG_N-1:0] tw;

  assign issuing    = (state_q == StIssue);
  assign fire       = issuing & issue_ready_i;
  assign pipe_empty = ~|pv_q;

  // Butterfly address decode from (stage, counter).
  always_comb begin
    lg    = inv_q ? s_q : (StW'(LOG_N - 1) - s_q);
    len   = LOG_N'(1) << lg;
    grp   = c_q >> lg;
    off   = c_q & (len - LOG_N'(1));
    idx_a = ((grp << lg) << 1) | off;
    idx_b = idx_a | len;
    // Forward: H/len + g. Inverse: 2H/len - 1 - g, where 2H/len - 1 is an all-ones
    // mask shifted down, which keeps the arithmetic inside LOG_N bits.
    if (inv_q) begin
      tw = ({LOG_N{1'b1}} >> lg) - grp;
    end else begin
      tw = (LOG_N'(Half) >> lg) + grp;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    inv_d   = inv_q;
    ct_d    = ct_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          inv_d   = inv_i;
          ct_d    = ~inv_i;
          s_d     = '0;
          c_d     = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (fire) begin
          if (c_q == LOG_N'(Half - 1)) begin
            state_d = StDrain;
          end else begin
            c_d = c_q + LOG_N'(1);
          end
        end
      end
      StDrain: begin
        // Next stage only after every write-back of this stage has retired.
        if (pipe_empty) begin
          c_d = '0;
          if (s_q == StW'(LOG_N - 1)) begin
            state_d = StDone;
          end else begin
            s_d     = s_q + StW'(1);
            state_d = StIssue;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Free-running write-back delay line; only handshaken pairs carry valid.
  always_comb begin
    pv_d[0] = fire;
    pa_d[0] = fire ? idx_a : '0;
    pb_d[0] = fire ? idx_b : '0;
    for (int i = 1; i < PIPE_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
      pb_d[i] = pb_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      s_q     <= '0;
      c_q     <= '0;
      inv_q   <= 1'b0;
      ct_q    <= 1'b0;
      pv_q    <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pa_q[i] <= '0;
        pb_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      inv_q   <= inv_d;
      ct_q    <= ct_d;
      pv_q    <= pv_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pa_q[i] <= pa_d[i];
        pb_q[i] <= pb_d[i];
      end
    end
  end

  assign busy_o        = (state_q == StIssue) || (state_q == StDrain);
  assign done_o        = (state_q == StDone);
  assign issue_valid_o = issuing;
  // Indices read as zero outside ISSUE so idle/reset outputs are all-zero.
  assign rd_a_idx_o    = issuing ? idx_a : '0;
  assign rd_b_idx_o    = issuing ? idx_b : '0;
  assign tw_idx_o      = issuing ? tw : '0;
  assign tw_neg_o      = inv_q;
  assign ct_mode_o     = ct_q;
  assign stage_o       = s_q;
  assign wr_en_o       = pv_q[PIPE_LAT-1];
  assign wr_a_idx_o    = pa_q[PIPE_LAT-1];
  assign wr_b_idx_o    = pb_q[PIPE_LAT-1];

endmodule

// File: doc/ntt_addr_gen.md
# ntt_addr_gen

Control and address-generation stage directly upstream of the butterfly unit in the NTT datapath. For an N = 2^LOG_N point transform over Dilithium's q = 8380417, it produces, every issue cycle, the coefficient-memory read indices (a, b), the twiddle ROM index and the butterfly mode. It also delays the same indices to drive write-back of the butterfly results. Supports forward (Cooley-Tukey) and inverse (Gentleman-Sande) ordering. The final inverse scaling by N^-1 happens downstream and is out of scope.

## Interface
- LOG_N, default 8: log2 of transform size; number of stages = LOG_N, butterflies per stage = 2^(LOG_N-1).
- PIPE_LAT, default 4: cycles from an issue handshake to the matching write-back (memory read latency plus butterfly latency); must be ≥ 1.

- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  begin a transform; sampled only in IDLE.
- inv_i  in  1  0 = forward/CT, 1 = inverse/GS; latched at start.
- busy_o  out  1  high from the cycle after start acceptance until done_o.
- done_o  out  1  one-cycle pulse after the last write-back.
- issue_valid_o  out  1  indices below are valid.
- issue_ready_i  in  1  butterfly/memory accepts the issue this cycle.
- rd_a_idx_o  out  LOG_N  coefficient index a.
- rd_b_idx_o  out  LOG_N  coefficient index b = a + len.
- tw_idx_o  out  LOG_N  twiddle ROM index.
- tw_neg_o  out  1  negate twiddle; equals the latched inv_i.
- ct_mode_o  out  1  equals the latched inverse of inv_i: 1 = CT, 0 = GS.
- stage_o  out  clog2(LOG_N)  current stage number, 0-based.
- wr_en_o  out  1  write-back strobe for both results.
- wr_a_idx_o  out  LOG_N  write index for the a result.
- wr_b_idx_o  out  LOG_N  write index for the b result.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE to ISSUE:
  - Taken on start_i = 1.
  - Latch inv_i; clear stage counter s and butterfly counter c.
- Stage length:
  - Forward: len = 2^(LOG_N-1-s).
  - Inverse: len = 2^s.
- Index generation, with lg = log2(len):
  - group g = c >> lg, offset o = c & (len-1).
  - a = g·2·len + o, b = a + len.
- Twiddle index, with H = 2^(LOG_N-1):
  - Forward: tw = H/len + g.
  - Inverse: tw = 2·H/len − 1 − g.
  - Example (N = 256): forward stage 0 gives tw = 1; inverse stage 0 covers tw 255 down to 128.
- ISSUE:
  - issue_valid_o = 1.
  - On issue_valid_o & issue_ready_i, increment c.
  - The handshake with c = H−1 moves the FSM to DRAIN.
- Stall: issue_ready_i = 0 holds every issue output stable. The delay line still advances.
- DRAIN:
  - issue_valid_o = 0; wait until no write-back is in flight (delay line empty).
  - Then, if s < LOG_N−1: s++, c = 0, back to ISSUE.
  - Otherwise go to DONE.
  - This guarantees stage s+1 never reads a coefficient before stage s has written it.
- DONE: assert done_o for one cycle, deassert busy_o, go to IDLE.
- Write-back delay line:
  - PIPE_LAT-deep shift register of {valid, a, b}, free-running every cycle.
  - It is loaded with the handshake indices; wr_en_o is the valid bit at the tail.
- start_i outside IDLE is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0, delay line cleared. Reset mid-transform aborts with no further wr_en_o.
- Throughput: one butterfly per cycle when issue_ready_i is held 1.
- Start and first issue:
  - Start accepted at edge T.
  - busy_o = 1 and the first issue_valid_o = 1 in cycle T+1.
- Write-back latency: the handshake at edge E produces wr_en_o with the same indices in the cycle after edge E+PIPE_LAT−1, i.e. PIPE_LAT cycles later.
- Stage gap: the first issue of the next stage occurs exactly PIPE_LAT+1 cycles after the last handshake of the previous stage.
- Total, all-ready: LOG_N·(H + PIPE_LAT + 1) + 1 cycles from start to done_o.
  - N = 256, PIPE_LAT = 4: 8·133 + 1 = 1065.
- done_o and busy_o:
  - done_o rises in the cycle after DRAIN completes the final stage.
  - busy_o falls in the same cycle.

## Test plan
- Forward, issue_ready_i always 1, N = 256:
  - First three issues are (a,b,tw) = (0,128,1), (1,129,1), (2,130,1).
  - Stage 7 first issue is (0,1,128), second is (2,3,129).
  - done_o arrives 1065 cycles after start.
- Inverse, N = 256:
  - Stage 0 issues (0,1,255), (2,3,254).
  - Stage 7 issues (0,128,1).
  - tw_neg_o = 1 and ct_mode_o = 0 throughout.
- Random issue_ready_i (50%):
  - Held issues keep all outputs stable.
  - Every index 0..255 is written exactly once per stage.
  - No read of a stage-s+1 index before its stage-s write.
- Write-back: each wr_en_o matches the handshake PIPE_LAT cycles earlier. Run with PIPE_LAT = 1 and PIPE_LAT = 6.
- start_i pulsed during a transform is ignored, and the issued sequence is unchanged.
- rst_ni asserted mid-stage 3:
  - All outputs go to 0 immediately and no wr_en_o follows.
  - A fresh start then reproduces the first scenario exactly.
